// File: rtl/tb_uart.sv
// Bench-side 8N1 UART peer: serializes tx_data on ser_tx, deserializes ser_rx into rx_data.
// Latency: ser_tx/tx_busy change 1 clock after tx_start is sampled; rx_valid at stop-bit midpoint.
// Backpressure: none on RX; TX uses a level tx_start request with tx_busy and tx_clear_req handshake.
// Optional line-end detect on rx_eol is built only when TB_UART_EOL_EN is defined.
module tb_uart #(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       ser_tx,
  output logic       tx_busy,
  output logic       tx_clear_req,
  input  logic       ser_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_eol
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- TX ----------------
  tx_state_t     tx_state_q;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_arm_q, tx_arm_d;
  logic          ser_tx_q, tx_busy_q, tx_clear_q;
  logic          tx_go, tx_bit_end;

  // Frame start decision, arm flag and per-bit cycle counter
  always_comb begin
    tx_go      = (tx_state_q == TX_IDLE) && tx_start && tx_arm_q;
    tx_bit_end = (tx_cnt_q == BIT_LAST);
    tx_arm_d   = tx_arm_q;
    if (!tx_start) tx_arm_d = 1'b1;
    else if (tx_go) tx_arm_d = 1'b0;
    if ((tx_state_q == TX_IDLE) || (tx_state_q == TX_DONE) || tx_bit_end) tx_cnt_d = '0;
    else tx_cnt_d = tx_cnt_q + CW'(1);
  end

  // Arm flag and counter registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_arm_q <= 1'b0;
      tx_cnt_q <= '0;
    end else begin
      tx_arm_q <= tx_arm_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // TX FSM with registered line, busy and clear-request outputs
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_state_q <= TX_IDLE;
      tx_shift_q <= '0;
      tx_bit_q   <= '0;
      ser_tx_q   <= 1'b1;
      tx_busy_q  <= 1'b0;
      tx_clear_q <= 1'b0;
    end else begin
      case (tx_state_q)
        TX_IDLE: if (tx_go) begin
          tx_shift_q <= tx_data;
          ser_tx_q   <= 1'b0;
          tx_busy_q  <= 1'b1;
          tx_state_q <= TX_START;
        end
        TX_START: if (tx_bit_end) begin
          ser_tx_q   <= tx_shift_q[0];
          tx_shift_q <= {1'b0, tx_shift_q[7:1]};
          tx_bit_q   <= '0;
          tx_state_q <= TX_DATA;
        end
        TX_DATA: if (tx_bit_end) begin
          if (tx_bit_q == 3'd7) begin
            ser_tx_q   <= 1'b1;
            tx_state_q <= TX_STOP;
          end else begin
            ser_tx_q   <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= tx_bit_q + 3'd1;
          end
        end
        TX_STOP: if (tx_bit_end) begin
          tx_busy_q  <= 1'b0;
          tx_clear_q <= tx_start;
          tx_state_q <= tx_start ? TX_DONE : TX_IDLE;
        end
        TX_DONE: if (!tx_start) begin
          tx_clear_q <= 1'b0;
          tx_state_q <= TX_IDLE;
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign ser_tx       = ser_tx_q;
  assign tx_busy      = tx_busy_q;
  assign tx_clear_req = tx_clear_q;

  // ---------------- RX ----------------
  rx_state_t     rx_state_q;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q, rx_data_q;
  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic          rx_valid_q, rx_ferr_q;
  logic          rx_stop_hit;

  // Two-flop synchronizer plus one delayed copy for falling-edge detect; idle high
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= ser_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Start bit is re-sampled after half a bit; later samples land one full bit apart
  always_comb begin
    rx_stop_hit = (rx_state_q == RX_STOP) && (rx_cnt_q == BIT_LAST);
    if ((rx_state_q == RX_IDLE) ||
        ((rx_state_q == RX_START) && (rx_cnt_q == HALF_LAST)) ||
        ((rx_state_q != RX_START) && (rx_cnt_q == BIT_LAST)))
      rx_cnt_d = '0;
    else
      rx_cnt_d = rx_cnt_q + CW'(1);
  end

  // RX FSM with one-cycle result strobes
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_cnt_q   <= rx_cnt_d;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      case (rx_state_q)
        RX_IDLE: if (rx_prev_q && !rx_s2_q) rx_state_q <= RX_START;
        RX_START: if (rx_cnt_q == HALF_LAST) begin
          rx_bit_q   <= '0;
          rx_state_q <= rx_s2_q ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_cnt_q == BIT_LAST) begin
          rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
        end
        RX_STOP: if (rx_stop_hit) begin
          if (rx_s2_q) begin
            rx_data_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
          end else begin
            rx_ferr_q  <= 1'b1;
          end
          rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_ferr_q;

`ifdef TB_UART_EOL_EN
  logic rx_eol_q;

  // Line-feed flag, aligned with rx_valid
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) rx_eol_q <= 1'b0;
    else         rx_eol_q <= rx_stop_hit && rx_s2_q && (rx_shift_q == 8'h0A);
  end

  assign rx_eol = rx_eol_q;
`else
  assign rx_eol = 1'b0;
`endif

endmodule

// File: tb/tb_tb_uart.sv
// Directed bench for tb_uart with CLKS_PER_BIT=4.
// TX line is checked bit by bit; RX results go through an expected-event queue
// that a separate monitor drains whenever rx_valid or rx_frame_err fires.
`timescale 1ns/1ps
module tb_tb_uart;

  localparam int CPB = 4;
`ifdef TB_UART_EOL_EN
  localparam logic EOL_ON = 1'b1;
`else
  localparam logic EOL_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       resetb = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       ser_tx, tx_busy, tx_clear_req;
  logic       ser_rx;
  logic       rx_drv = 1'b1;
  logic       loop_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_eol;

  assign ser_rx = loop_en ? ser_tx : rx_drv;

  tb_uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .ser_tx       (ser_tx),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .ser_rx       (ser_rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_eol       (rx_eol)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       eol;
  } rx_exp_t;

  rx_exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic err, input logic eol);
    rx_exp_t e;
    e.data = d;
    e.err  = err;
    e.eol  = eol;
    exp_q.push_back(e);
  endtask

  // RX scoreboard monitor
  always @(negedge clock) begin : rx_monitor
    rx_exp_t e;
    if (resetb && (rx_valid || rx_frame_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got data %0h valid %0b err %0b, expected no event",
                 rx_data, rx_valid, rx_frame_err);
      end else begin
        e = exp_q.pop_front();
        check("rx_valid", {31'b0, rx_valid}, {31'b0, !e.err});
        check("rx_frame_err", {31'b0, rx_frame_err}, {31'b0, e.err});
        check("rx_data", {24'b0, rx_data}, {24'b0, e.data});
        check("rx_eol", {31'b0, rx_eol}, {31'b0, e.eol});
      end
    end
  end

  // Send one byte, check every bit of ser_tx at its midpoint; leaves tx_start high
  task automatic tx_frame(input logic [7:0] b, input logic [9:0] bits, input string tag);
    logic seen;
    int   n;
    @(negedge clock);
    tx_data  = b;
    tx_start = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 2 && !seen; i++) begin
      @(negedge clock);
      seen = tx_busy;
    end
    check({tag, "_busy_rise"}, {31'b0, seen}, 32'd1);
    if (!seen) return;
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 2 : CPB) @(negedge clock);
      check($sformatf("%s_bit%0d", tag, k), {31'b0, ser_tx}, {31'b0, bits[k]});
      if (k == 3) tx_data = ~b;
    end
    n = 0;
    while (tx_busy && n < 8) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_busy_fall"}, {31'b0, tx_busy}, 32'd0);
  endtask

  // Drive one raw frame onto ser_rx
  task automatic rx_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      rx_drv = f[k];
      repeat (CPB - 1) @(negedge clock);
    end
    @(negedge clock);
    rx_drv = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin : stim
    int busy_cnt;
    int seen;

    // Reset values
    repeat (3) @(negedge clock);
    check("rst_ser_tx", {31'b0, ser_tx}, 32'd1);
    check("rst_tx_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_tx_clear_req", {31'b0, tx_clear_req}, 32'd0);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_frame_err", {31'b0, rx_frame_err}, 32'd0);
    check("rst_rx_eol", {31'b0, rx_eol}, 32'd0);
    resetb = 1'b1;
    repeat (3) @(negedge clock);

    // TX 0x0F held high: one frame, then clear request
    tx_frame(8'h0F, 10'b1000011110, "tx0f");
    check("tx0f_clear_req", {31'b0, tx_clear_req}, 32'd1);
    busy_cnt = 0;
    repeat (8) begin
      @(negedge clock);
      busy_cnt += int'(tx_busy);
    end
    check("tx0f_single_frame", busy_cnt, 32'd0);
    check("tx0f_clear_held", {31'b0, tx_clear_req}, 32'd1);
    tx_start = 1'b0;
    repeat (2) @(negedge clock);
    check("tx0f_clear_drop", {31'b0, tx_clear_req}, 32'd0);

    // Loopback 0x3D then 0x0A
    loop_en = 1'b1;
    repeat (2) @(negedge clock);
    push(8'h3D, 1'b0, 1'b0);
    tx_frame(8'h3D, 10'b1001111010, "lb3d");
    tx_start = 1'b0;
    push(8'h0A, 1'b0, EOL_ON);
    tx_frame(8'h0A, 10'b1000010100, "lb0a");
    tx_start = 1'b0;
    repeat (10) @(negedge clock);
    check("lb_drained", exp_q.size(), 32'd0);
    loop_en = 1'b0;
    repeat (4) @(negedge clock);

    // Framing error: rx_data keeps the last good byte
    push(8'h0A, 1'b1, 1'b0);
    rx_send(8'hA5, 1'b0);
    repeat (10) @(negedge clock);
    check("ferr_drained", exp_q.size(), 32'd0);

    // One-clock glitch must not produce a byte; a clean frame follows
    @(negedge clock);
    rx_drv = 1'b0;
    @(negedge clock);
    rx_drv = 1'b1;
    repeat (50) @(negedge clock);
    push(8'hC3, 1'b0, 1'b0);
    rx_send(8'hC3, 1'b1);
    repeat (10) @(negedge clock);
    check("glitch_recover_drained", exp_q.size(), 32'd0);

    // Reset in the middle of the TX data phase
    loop_en = 1'b1;
    repeat (2) @(negedge clock);
    tx_data  = 8'h55;
    tx_start = 1'b1;
    seen = 0;
    for (int i = 0; i < 2 && seen == 0; i++) begin
      @(negedge clock);
      seen = int'(tx_busy);
    end
    check("midrst_busy_rise", seen, 32'd1);
    repeat (9) @(negedge clock);
    check("midrst_pre_ser_tx", {31'b0, ser_tx}, 32'd0);
    resetb   = 1'b0;
    tx_start = 1'b0;
    #1;
    check("midrst_ser_tx", {31'b0, ser_tx}, 32'd1);
    check("midrst_tx_busy", {31'b0, tx_busy}, 32'd0);
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    repeat (2) @(negedge clock);
    push(8'h55, 1'b0, 1'b0);
    tx_frame(8'h55, 10'b1010101010, "midrst55");
    tx_start = 1'b0;
    repeat (10) @(negedge clock);
    check("midrst_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
